// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// It feeds one nibble at a time to a shared decoder, blanks between digits and swaps data only at frame edges.
module seg7_scan_ctrl #(
    parameter int NDIGITS  = 4,
    parameter int PRESCALE = 50000,
    parameter int BLANK    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4*NDIGITS-1:0]   Value,
    input  logic [NDIGITS-1:0]     DpIn,
    input  logic                   Load,
    input  logic                   Enable,
    input  logic                   LzSuppress,
    output logic [3:0]             BinOut,
    output logic [NDIGITS-1:0]     AnOut,
    output logic                   DpOut,
    output logic                   FrameDone,
    output logic                   Pending
);

    localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [IW-1:0] IDX_LAST        = IW'(NDIGITS - 1);
    localparam logic [CW-1:0] CNT_LAST        = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] CNT_BLANK_LAST  = CW'(BLANK - 1);
    localparam logic [CW-1:0] CNT_DRIVE_FIRST = CW'(BLANK);

    typedef enum logic [1:0] {
        S_OFF,
        S_BLANK,
        S_DRIVE
    } state_t;

    state_t                 r_state;
    logic [IW-1:0]          r_idx;
    logic [CW-1:0]          r_cnt;
    logic [4*NDIGITS-1:0]   r_shadow_val;
    logic [NDIGITS-1:0]     r_shadow_dp;
    logic [4*NDIGITS-1:0]   r_active_val;
    logic [NDIGITS-1:0]     r_active_dp;
    logic                   r_pending;
    logic [3:0]             r_bin;
    logic [NDIGITS-1:0]     r_an;
    logic                   r_dp;
    logic                   r_frame_done;

    state_t                 w_state;
    logic [IW-1:0]          w_idx;
    logic [CW-1:0]          w_cnt;
    logic                   w_apply;
    logic                   w_wrap;
    logic [4*NDIGITS-1:0]   w_active_val;
    logic [NDIGITS-1:0]     w_active_dp;
    logic [NDIGITS-1:0]     w_supp;
    logic                   w_run;
    logic [3:0]             w_nib;
    logic                   w_show;

    // NOTE: every signal gets a default at the top of the block so no path leaves it unassigned (no latch).
    always_comb begin
        w_state = r_state;
        w_idx   = r_idx;
        w_cnt   = r_cnt;
        w_apply = 1'b0;
        w_wrap  = 1'b0;
        case (r_state)
            S_OFF: begin
                w_idx = '0;
                w_cnt = '0;
                if (Enable) begin
                    w_state = S_BLANK;
                    w_apply = r_pending;
                end
            end
            S_BLANK: begin
                if (!Enable) begin
                    w_state = S_OFF;
                    w_idx   = '0;
                    w_cnt   = '0;
                end else if (r_cnt == CNT_BLANK_LAST) begin
                    w_state = S_DRIVE;
                    w_cnt   = CNT_DRIVE_FIRST;
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
            end
            S_DRIVE: begin
                if (!Enable) begin
                    w_state = S_OFF;
                    w_idx   = '0;
                    w_cnt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state = S_BLANK;
                    w_cnt   = '0;
                    if (r_idx == IDX_LAST) begin
                        w_idx   = '0;
                        w_wrap  = 1'b1;
                        w_apply = r_pending;
                    end else begin
                        w_idx = r_idx + IW'(1);
                    end
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state = S_OFF;
                w_idx   = '0;
                w_cnt   = '0;
            end
        endcase
    end

    assign w_active_val = w_apply ? r_shadow_val : r_active_val;
    assign w_active_dp  = w_apply ? r_shadow_dp  : r_active_dp;

    // A digit is dark while it and every higher digit carry a zero nibble and no decimal point.
    always_comb begin
        w_run  = 1'b1;
        w_supp = '0;
        for (int k = NDIGITS - 1; k >= 1; k--) begin
            w_run     = w_run & (w_active_val[4*k +: 4] == 4'h0) & ~w_active_dp[k];
            w_supp[k] = LzSuppress & w_run;
        end
    end

    assign w_nib  = w_active_val[{w_idx, 2'b00} +: 4];
    assign w_show = (w_state == S_DRIVE) && !w_supp[w_idx];

    // Outputs are computed from next-state values so they line up with the state they describe.
    // NOTE: sequential state uses non-blocking assignments only; blocking here would race other always_ff blocks.
    // NOTE: shadow/active data are plain registers, not a memory, and are reset so a stale value can never be applied.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_OFF;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_shadow_val <= '0;
            r_shadow_dp  <= '0;
            r_active_val <= '0;
            r_active_dp  <= '0;
            r_pending    <= 1'b0;
            r_bin        <= 4'h0;
            r_an         <= '1;
            r_dp         <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_idx        <= w_idx;
            r_cnt        <= w_cnt;
            r_active_val <= w_active_val;
            r_active_dp  <= w_active_dp;
            if (Load) begin
                r_shadow_val <= Value;
                r_shadow_dp  <= DpIn;
            end
            r_pending    <= Load | (r_pending & ~w_apply);
            r_bin        <= (w_state == S_OFF) ? 4'h0 : w_nib;
            r_an         <= w_show ? ~(NDIGITS'(1) << w_idx) : '1;
            r_dp         <= w_show ? ~w_active_dp[w_idx] : 1'b1;
            r_frame_done <= w_wrap;
        end
    end

    assign BinOut    = r_bin;
    assign AnOut     = r_an;
    assign DpOut     = r_dp;
    assign FrameDone = r_frame_done;
    assign Pending   = r_pending;

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Time-multiplexed scan controller for a common-anode multi-digit 7-segment display. A single shared Transcodeur7Seg instance serves all digits: the block feeds it one nibble at a time and drives the active-low digit anodes. Dead-time blanking prevents ghosting. A double-buffered load, applied only at frame boundaries, prevents tearing. Sits between the application's value registers and the display pins.

Parameters:
NDIGITS, 4, number of digits scanned (2..8)
PRESCALE, 50000, clocks per digit slot (blank + drive); legal range BLANK+1..2^20
BLANK, 16, dead-time clocks at the start of each slot, all anodes off (1..PRESCALE-1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
Value  in  4*NDIGITS  nibble per digit; digit k = Value[4k+3:4k]; digit 0 rightmost
DpIn  in  NDIGITS  decimal point per digit, 1 = lit
Load  in  1  1-cycle strobe: capture Value/DpIn into shadow register
Enable  in  1  1 = scanning, 0 = display dark
LzSuppress  in  1  1 = blank leading zero digits
BinOut  out  4  nibble to shared Transcodeur7Seg BinIn
AnOut  out  NDIGITS  digit anodes, active-low
DpOut  out  1  decimal point segment, active-low
FrameDone  out  1  1-cycle pulse at end of last digit slot
Pending  out  1  shadow loaded, not yet applied

Behaviour:
- One clock domain. Reset is synchronous and active-high (rst sampled on rising clk); it overrides everything.
- Reset values: AnOut all 1; DpOut 1; BinOut 0; FrameDone 0; Pending 0; active and shadow registers 0; digit index 0; slot counter 0; state OFF.
- Registers: shadow (Value,DpIn), active (Value,DpIn), pending flag, digit index 0..NDIGITS-1, slot counter 0..PRESCALE-1.
- States: OFF, BLANK, DRIVE. All outputs are registered.
- OFF: anodes all 1, DpOut 1, counters held at 0.
  - Enable=1 -> BLANK for digit 0 next cycle, slot counter 0.
  - First-enable apply: if pending=1 on OFF->BLANK, active <= shadow and pending clears in the same cycle, so digit 0 is scanned from the loaded value.
- BLANK: anodes all 1; DpOut 1; BinOut = active nibble of current digit.
  - Lasts exactly BLANK cycles (counter 0..BLANK-1), then -> DRIVE.
- DRIVE: AnOut[idx]=0, all other anodes 1; DpOut = ~DpIn_active[idx].
  - Lasts PRESCALE-BLANK cycles (counter BLANK..PRESCALE-1).
  - At counter = PRESCALE-1: counter wraps to 0, idx increments, -> BLANK.
- Wrap-around:
  - After DRIVE of idx=NDIGITS-1, idx -> 0 and FrameDone=1 for that single cycle.
  - If pending=1 at that cycle: active <= shadow and pending clears in the same cycle.
- Load: shadow <= {Value,DpIn} and pending=1 on the next edge.
  - Load in any state, including OFF, is accepted.
  - Load in the same cycle as frame-end apply: the old shadow is applied and the new data is captured, so pending stays 1.
  - Repeated Load overwrites the shadow; last one wins.
- Leading-zero suppression (LzSuppress=1): digit k is suppressed if its nibble and all higher-index nibbles in active are 0, for k>=1.
  - Digit 0 is never suppressed.
  - A suppressed digit keeps its slot timing, but its anode stays 1 during DRIVE and DpOut is 1.
  - If the DP of a suppressed digit is set, the digit is still shown (DP breaks suppression for that digit and all lower digits).
- Enable falling mid-slot: -> OFF on the next edge; anodes 1; idx and counter reset to 0; no FrameDone.
- rst mid-frame: all state returns to reset values on the next edge; shadow and pending are cleared.
- Frame period = NDIGITS*PRESCALE clocks.

Test Plan:
All scenarios use NDIGITS=4, PRESCALE=8, BLANK=2.
1. Reset, then Enable=1 with Load of Value=16'h1234: active is applied on OFF->BLANK. Digit 0: AnOut=4'b1111 for 2 cycles with BinOut=4, then AnOut=4'b1110 for 6 cycles. Digits 1,2,3 follow with BinOut 3,2,1. FrameDone pulses once, 32 cycles after scan start.
2. Load 16'hABCD at cycle 5 of the frame: Pending=1, display stays 1234 until FrameDone; next frame shows D,C,B,A; Pending=0.
3. LzSuppress=1, Value=16'h0070: digits 3 and 2 anodes stay 1 throughout; digit 1 shows 7; digit 0 shows 0. Frame is still 32 cycles.
4. Same as 3 with DpIn=4'b0100: digit 2 is shown (BinOut=0, DpOut=0); digit 3 is still suppressed.
5. Drop Enable during DRIVE of digit 2: next cycle AnOut=4'b1111. Re-enable: scan restarts at digit 0 with BLANK.
6. Load asserted in the FrameDone cycle with the shadow already pending: the old shadow is displayed next frame, Pending stays 1, and the new value appears the frame after. rst mid-DRIVE: all outputs return to reset values on the next edge.
